// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge event arbiter.
//   - EDGE_ARB_N  : default number of level input channels
//   - det_state_e : per-channel rising-edge detector state (2'b11 is unused
//                   and treated as ZERO by the detector)
//   - arb_state_e : round-robin arbiter state
package edge_arb_pkg;

  localparam int EDGE_ARB_N = 4;

  typedef enum logic [1:0] {
    DET_ZERO = 2'b00,
    DET_EDGE = 2'b01,
    DET_ONE  = 2'b10
  } det_state_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_tick_fsm.sv
// One channel of the edge event front end: a 2-flop synchronizer followed by
// a 3-state Moore rising-edge detector.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   level : raw asynchronous level input
//   tick  : high for exactly one cycle per rising edge of the synchronized level
module edge_tick_fsm
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  logic       s1_q;
  logic       s2_q;
  det_state_e det_q;
  det_state_e det_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      det_q <= DET_ZERO;
    end else begin
      s1_q  <= level;
      s2_q  <= s1_q;
      det_q <= det_d;
    end
  end

  always_comb begin
    det_d = DET_ZERO;
    case (det_q)
      DET_ZERO: det_d = s2_q ? DET_EDGE : DET_ZERO;
      DET_EDGE: det_d = s2_q ? DET_ONE  : DET_ZERO;
      DET_ONE:  det_d = s2_q ? DET_ONE  : DET_ZERO;
      // The unused encoding behaves exactly like ZERO.
      default:  det_d = s2_q ? DET_EDGE : DET_ZERO;
    endcase
  end

  assign tick = (det_q == DET_EDGE);

endmodule

// File: rtl/edge_event_arbiter.sv
// Turns rising edges on N asynchronous level inputs into queued events and
// hands them one at a time to a single consumer with round-robin priority.
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   level     : [N-1:0] raw asynchronous level inputs
//   ev_ready  : consumer accepts the offered event
//   clear_ovf : one-cycle pulse clearing all overflow flags
//   ev_valid  : an event is offered on ev_id
//   ev_id     : [IDW-1:0] channel of the offered event
//   pending   : [N-1:0] per-channel queued-event flags
//   overflow  : [N-1:0] sticky, an edge arrived while already pending
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = EDGE_ARB_N,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level,
  input  logic           ev_ready,
  input  logic           clear_ovf,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow
);

  logic [N-1:0]   tick;
  logic [N-1:0]   load;
  logic [N-1:0]   new_ovf;
  logic [N-1:0]   pending_q,  pending_d;
  logic [N-1:0]   overflow_q, overflow_d;

  arb_state_e     state_q, state_d;
  logic           ev_valid_q, ev_valid_d;
  logic [IDW-1:0] ev_id_q, ev_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic [IDW-1:0] pick;
  logic           pick_found;
  logic           arb_load;
  int             idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      edge_tick_fsm u_tick (
        .clk   (clk),
        .reset (reset),
        .level (level[gi]),
        .tick  (tick[gi])
      );

      assign load[gi] = arb_load && (int'(pick) == gi);

      // A grant wins over a simultaneous tick: the new edge simply keeps the
      // channel queued, so it is not an overflow.
      assign pending_d[gi]  = load[gi] ? tick[gi] : (tick[gi] | pending_q[gi]);
      assign new_ovf[gi]    = tick[gi] & pending_q[gi] & ~load[gi];
      assign overflow_d[gi] = new_ovf[gi] | (overflow_q[gi] & ~clear_ovf);
    end
  endgenerate

  // Round-robin search: first pending channel strictly after last_grant,
  // wrapping modulo N (last_grant itself is checked last).
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_found && pending_q[IDW'(idx)]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ev_valid_d   = ev_valid_q;
    ev_id_d      = ev_id_q;
    last_grant_d = last_grant_q;
    arb_load     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        ev_valid_d = 1'b0;
        if (pick_found) begin
          arb_load   = 1'b1;
          ev_id_d    = pick;
          ev_valid_d = 1'b1;
          state_d    = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        // Returning to IDLE after acceptance creates the one-cycle bubble.
        if (ev_valid_q && ev_ready) begin
          last_grant_d = ev_id_q;
          ev_valid_d   = 1'b0;
          state_d      = ARB_IDLE;
        end
      end
      default: begin
        ev_valid_d = 1'b0;
        state_d    = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      ev_valid_q   <= 1'b0;
      ev_id_q      <= '0;
      last_grant_q <= IDW'(N - 1);
      pending_q    <= '0;
      overflow_q   <= '0;
    end else begin
      state_q      <= state_d;
      ev_valid_q   <= ev_valid_d;
      ev_id_q      <= ev_id_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level = 4'h0;
  logic       ev_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [3:0] pending;
  logic [3:0] overflow;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          prev_hs = -1;
  bit          gap_check = 1'b0;
  int          sb[$];
  logic [31:0] exp_id;

  edge_event_arbiter #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .ev_ready  (ev_ready),
    .clear_ovf (clear_ovf),
    .ev_valid  (ev_valid),
    .ev_id     (ev_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, obs, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ev_valid && n < budget) begin
      step(1);
      n++;
    end
    check_value("wait_valid", 32'(ev_valid), 1);
  endtask

  // Scoreboard: every accepted event is matched against the queue.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      exp_id = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
      check_value("ev_id_accept", 32'(ev_id), exp_id);
      if (gap_check && prev_hs >= 0) check_value("ev_gap", 32'(cyc - prev_hs), 2);
      prev_hs = cyc;
    end
  end

  initial begin
    // Reset state
    step(2);
    check_value("rst_ev_valid", 32'(ev_valid), 0);
    check_value("rst_ev_id", 32'(ev_id), 0);
    check_value("rst_pending", 32'(pending), 0);
    check_value("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;

    // 1: single held level on ch2 gives exactly one event, 4 edges later
    ev_ready = 1'b1;
    level[2] = 1'b1;
    sb.push_back(2);
    step(4);
    check_value("t1_valid_k3", 32'(ev_valid), 0);
    check_value("t1_pending_k3", 32'(pending), 32'h4);
    step(1);
    check_value("t1_valid_k4", 32'(ev_valid), 1);
    check_value("t1_id_k4", 32'(ev_id), 2);
    step(1);
    check_value("t1_valid_k5", 32'(ev_valid), 0);
    step(50);
    check_value("t1_sb_empty", 32'(sb.size()), 0);
    check_value("t1_pending_end", 32'(pending), 0);
    level = 4'h0;

    // 2: all channels at once, granted 0..3 with a bubble between each
    do_reset();
    prev_hs = -1;
    gap_check = 1'b1;
    ev_ready = 1'b1;
    level = 4'hF;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    step(20);
    gap_check = 1'b0;
    check_value("t2_sb_empty", 32'(sb.size()), 0);
    check_value("t2_pending_end", 32'(pending), 0);
    level = 4'h0;

    // 3: ch1 held in OFFER, two more edges -> requeue + overflow
    do_reset();
    ev_ready = 1'b0;
    level[1] = 1'b1;
    sb.push_back(1);
    wait_valid(20);
    check_value("t3_id_offer", 32'(ev_id), 1);
    for (int i = 0; i < 8; i++) begin
      level[1] = (i % 4 >= 2);
      step(1);
      check_value("t3_hold_valid", 32'(ev_valid), 1);
      check_value("t3_hold_id", 32'(ev_id), 1);
    end
    step(5);
    check_value("t3_pending1", 32'(pending), 32'h2);
    check_value("t3_overflow1", 32'(overflow), 32'h2);
    sb.push_back(1);
    ev_ready = 1'b1;
    step(12);
    check_value("t3_sb_empty", 32'(sb.size()), 0);
    check_value("t3_pending_end", 32'(pending), 0);
    check_value("t3_ovf_sticky", 32'(overflow), 32'h2);
    level = 4'h0;

    // 4: clear_ovf coincident with a new overflow on ch3 -> set wins
    do_reset();
    ev_ready = 1'b0;
    level[0] = 1'b1;
    sb.push_back(0);
    wait_valid(20);
    for (int i = 0; i < 8; i++) begin
      level[0] = (i % 4 >= 2);
      step(1);
    end
    step(5);
    check_value("t4_ovf0", 32'(overflow), 32'h1);
    level[3] = 1'b1;
    step(6);
    check_value("t4_pending03", 32'(pending), 32'h9);
    level[3] = 1'b0;
    step(3);
    level[3] = 1'b1;
    step(3);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    check_value("t4_ovf_setwins", 32'(overflow), 32'h8);
    step(1);
    check_value("t4_ovf_hold", 32'(overflow), 32'h8);
    sb.push_back(3); sb.push_back(0);
    ev_ready = 1'b1;
    step(20);
    check_value("t4_sb_empty", 32'(sb.size()), 0);
    level = 4'h0;

    // 5: asynchronous reset in the middle of an offer
    do_reset();
    ev_ready = 1'b0;
    level = 4'hF;
    wait_valid(20);
    check_value("t5_first_id", 32'(ev_id), 0);
    reset = 1'b1;
    #2;
    check_value("t5_async_valid", 32'(ev_valid), 0);
    check_value("t5_async_pending", 32'(pending), 0);
    check_value("t5_async_ovf", 32'(overflow), 0);
    step(2);
    reset = 1'b0;
    prev_hs = -1;
    gap_check = 1'b1;
    ev_ready = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
    step(25);
    gap_check = 1'b0;
    check_value("t5_sb_empty", 32'(sb.size()), 0);
    level = 4'h0;

    // 6: 1-cycle glitch then a 3-cycle pulse on ch1 -> two events
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      level[1] = (i == 0) || (i >= 3 && i <= 5);
      if (i == 0 || i == 3) sb.push_back(1);
      step(1);
    end
    step(15);
    check_value("t6_sb_empty", 32'(sb.size()), 0);
    check_value("t6_overflow", 32'(overflow), 0);
    check_value("t6_pending", 32'(pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
